// File: rtl/def.sv
// Shared definitions for the ALU arbiter: op encoding, ALU control word,
// response entry layout and the default response buffer depth.
package def;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned ID_W          = 1;
  localparam int unsigned RSP_DEPTH_DEF = 2;

  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } alu_op_e;

  typedef struct packed {
    logic sub;
    logic add;
  } control_info;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } rsp_entry_t;

  function automatic control_info op_to_ctr(input alu_op_e op);
    control_info ctr;
    ctr     = '0;
    ctr.add = (op == ADD);
    ctr.sub = (op == SUB);
    return ctr;
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Response buffer: power-of-two depth ring of {id, data} entries.
// Pointers wrap naturally; the caller guarantees no push on full / pop on empty.
module rsp_fifo
  import def::*;
#(
  parameter int unsigned DEPTH = RSP_DEPTH_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     PUSH,
  input  rsp_entry_t               PUSH_DATA,
  input  logic                     POP,
  output rsp_entry_t               HEAD,
  output logic                     VALID,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rsp_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (PUSH) wr_ptr <= wr_ptr + AW'(1);
      if (POP)  rd_ptr <= rd_ptr + AW'(1);
      case ({PUSH, POP})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge CLK) begin
    if (PUSH) mem[wr_ptr] <= PUSH_DATA;
  end

  assign VALID = (count != '0);
  assign HEAD  = mem[rd_ptr];
  assign COUNT = count;

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared, one-cycle-latency ALU,
// with a credit-checked response FIFO returning results in issue order.
module alu_arbiter
  import def::*;
#(
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        REQ_VALID,
  output logic [1:0]        REQ_READY,
  input  alu_op_e           REQ_OP0,
  input  alu_op_e           REQ_OP1,
  input  logic [DATA_W-1:0] REQ_A0,
  input  logic [DATA_W-1:0] REQ_B0,
  input  logic [DATA_W-1:0] REQ_A1,
  input  logic [DATA_W-1:0] REQ_B1,
  output control_info       ALU_CTR,
  output logic [DATA_W-1:0] ALU_RS1,
  output logic [DATA_W-1:0] ALU_RS2,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic              RSP_ID,
  output logic [DATA_W-1:0] RSP_DATA
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic            rr_ptr;
  logic            inflight_q;
  logic            inflight_id_q;
  logic [CW-1:0]   fifo_count;
  logic            fifo_valid;
  rsp_entry_t      fifo_head;
  rsp_entry_t      push_entry;
  logic            push;
  logic            pop;
  logic [OW-1:0]   occupied;
  logic            slot_free;
  logic            winner;
  logic            issue;

  assign pop  = RSP_VALID & RSP_READY;
  assign push = inflight_q & ~RST;

  // A slot freed by this cycle's pop can be reused by this cycle's issue.
  assign occupied  = OW'(fifo_count) + OW'(inflight_q);
  assign slot_free = (occupied - OW'(pop)) < OW'(RSP_DEPTH);

  always_comb begin
    winner = rr_ptr;
    if (REQ_VALID == 2'b01)      winner = 1'b0;
    else if (REQ_VALID == 2'b10) winner = 1'b1;
  end

  assign issue        = (|REQ_VALID) & slot_free & ~RST;
  assign REQ_READY[0] = issue & ~winner;
  assign REQ_READY[1] = issue &  winner;

  always_comb begin
    ALU_CTR = '0;
    ALU_RS1 = '0;
    ALU_RS2 = '0;
    if (issue) begin
      ALU_CTR = op_to_ctr(winner ? REQ_OP1 : REQ_OP0);
      ALU_RS1 = winner ? REQ_A1 : REQ_A0;
      ALU_RS2 = winner ? REQ_B1 : REQ_B0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr        <= 1'b0;
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_id_q <= winner;
        rr_ptr        <= ~winner;
      end
    end
  end

  assign push_entry = '{id: inflight_id_q, data: ALU_RESULT};

  rsp_fifo #(
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .PUSH     (push),
    .PUSH_DATA(push_entry),
    .POP      (pop),
    .HEAD     (fifo_head),
    .VALID    (fifo_valid),
    .COUNT    (fifo_count)
  );

  // Outputs forced quiet while reset is held, even before state has cleared.
  assign RSP_VALID = fifo_valid & ~RST;
  assign RSP_ID    = RSP_VALID & fifo_head.id[0];
  assign RSP_DATA  = RSP_VALID ? fifo_head.data : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural one-cycle ALU attached.
module tb_alu_arbiter;
  import def::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  REQ_VALID;
  logic [1:0]  REQ_READY;
  alu_op_e     REQ_OP0, REQ_OP1;
  logic [31:0] REQ_A0, REQ_B0, REQ_A1, REQ_B1;
  control_info ALU_CTR;
  logic [31:0] ALU_RS1, ALU_RS2, ALU_RESULT;
  logic        RSP_VALID, RSP_READY, RSP_ID;
  logic [31:0] RSP_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.RSP_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_OP0(REQ_OP0), .REQ_OP1(REQ_OP1),
    .REQ_A0(REQ_A0), .REQ_B0(REQ_B0), .REQ_A1(REQ_A1), .REQ_B1(REQ_B1),
    .ALU_CTR(ALU_CTR), .ALU_RS1(ALU_RS1), .ALU_RS2(ALU_RS2), .ALU_RESULT(ALU_RESULT),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA)
  );

  // Shared ALU outside the arbiter: registered result one cycle after issue.
  always_ff @(posedge CLK) begin
    if (ALU_CTR.add)      ALU_RESULT <= ALU_RS1 + ALU_RS2;
    else if (ALU_CTR.sub) ALU_RESULT <= ALU_RS1 - ALU_RS2;
    else                  ALU_RESULT <= '0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    REQ_VALID = 2'b00;
    REQ_OP0 = ADD; REQ_OP1 = ADD;
    REQ_A0 = '0; REQ_B0 = '0; REQ_A1 = '0; REQ_B1 = '0;
    RSP_READY = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    next_cycle();
    next_cycle();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b1;
    REQ_VALID = 2'b11;
    REQ_A0 = 32'd9; REQ_B0 = 32'd4; REQ_A1 = 32'd8; REQ_B1 = 32'd2;
    #1;
    n_checks++; if (REQ_READY !== 2'b00) begin n_fail++; $display("FAIL reset_rdy: got %b want 00", REQ_READY); end
    n_checks++; if (ALU_CTR !== 2'b00) begin n_fail++; $display("FAIL reset_ctr: got %b want 00", ALU_CTR); end
    n_checks++; if (ALU_RS1 !== 32'd0 || ALU_RS2 !== 32'd0) begin n_fail++; $display("FAIL reset_rs: got %h/%h want 0/0", ALU_RS1, ALU_RS2); end
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", RSP_VALID); end
    next_cycle();
    next_cycle();
    #1;
    n_checks++; if (REQ_READY !== 2'b00) begin n_fail++; $display("FAIL reset_rdy_held: got %b want 00", REQ_READY); end
    n_checks++; if (RSP_VALID !== 1'b0 || RSP_ID !== 1'b0 || RSP_DATA !== 32'd0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b/%h want 0/0/0", RSP_VALID, RSP_ID, RSP_DATA); end
    RST = 1'b0;
  endtask

  // Runs in the first cycle after reset release.
  task automatic test_single();
    idle_inputs();
    REQ_VALID = 2'b01; REQ_OP0 = ADD; REQ_A0 = 32'd5; REQ_B0 = 32'd7;
    #1;
    n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL single_rdy: got %b want 01", REQ_READY); end
    n_checks++; if (ALU_CTR !== 2'b01) begin n_fail++; $display("FAIL single_ctr: got %b want 01", ALU_CTR); end
    n_checks++; if (ALU_RS1 !== 32'd5 || ALU_RS2 !== 32'd7) begin n_fail++; $display("FAIL single_rs: got %h/%h want 5/7", ALU_RS1, ALU_RS2); end
    next_cycle();
    REQ_VALID = 2'b00;
    #1;
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b want 0", RSP_VALID); end
    n_checks++; if (ALU_CTR !== 2'b00) begin n_fail++; $display("FAIL single_ctr_idle: got %b want 00", ALU_CTR); end
    next_cycle();
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b0 || RSP_DATA !== 32'd12) begin n_fail++; $display("FAIL single_rsp: got %b/%b/%h want 1/0/0000000c", RSP_VALID, RSP_ID, RSP_DATA); end
    next_cycle();
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b want 0", RSP_VALID); end
  endtask

  task automatic test_contention();
    logic [1:0]  exp_rdy;
    logic        exp_id;
    logic [31:0] exp_data;
    do_reset();
    REQ_VALID = 2'b11;
    REQ_OP0 = ADD; REQ_A0 = 32'd1; REQ_B0 = 32'd2;
    REQ_OP1 = SUB; REQ_A1 = 32'd3; REQ_B1 = 32'd5;
    RSP_READY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) REQ_VALID = 2'b00;
      #1;
      if (k < 4) begin
        exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
        n_checks++; if (REQ_READY !== exp_rdy) begin n_fail++; $display("FAIL contention_grant%0d: got %b want %b", k, REQ_READY, exp_rdy); end
      end
      if (k >= 2) begin
        exp_id   = ((k - 2) % 2 == 1);
        exp_data = exp_id ? 32'hFFFF_FFFE : 32'd3;
        n_checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== exp_id || RSP_DATA !== exp_data) begin n_fail++; $display("FAIL contention_rsp%0d: got %b/%b/%h want 1/%b/%h", k - 2, RSP_VALID, RSP_ID, RSP_DATA, exp_id, exp_data); end
      end
      next_cycle();
    end
    #1;
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL contention_drain: got %b want 0", RSP_VALID); end
  endtask

  task automatic test_backpressure();
    do_reset();
    RSP_READY = 1'b0;
    REQ_VALID = 2'b01; REQ_OP0 = ADD; REQ_B0 = 32'd1;
    REQ_A0 = 32'd10; #1;
    n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL bp_accept0: got %b want 01", REQ_READY); end
    next_cycle();
    REQ_A0 = 32'd20; #1;
    n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL bp_accept1: got %b want 01", REQ_READY); end
    next_cycle();
    REQ_A0 = 32'd30;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (REQ_READY !== 2'b00) begin n_fail++; $display("FAIL bp_full%0d: got %b want 00", k, REQ_READY); end
      n_checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 32'd11) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%h want 1/0000000b", k, RSP_VALID, RSP_DATA); end
      next_cycle();
    end
    RSP_READY = 1'b1; #1;
    n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL bp_resume: got %b want 01", REQ_READY); end
    n_checks++; if (RSP_DATA !== 32'd11) begin n_fail++; $display("FAIL bp_pop0: got %h want 0000000b", RSP_DATA); end
    next_cycle();
    REQ_VALID = 2'b00; #1;
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 32'd21) begin n_fail++; $display("FAIL bp_pop1: got %b/%h want 1/00000015", RSP_VALID, RSP_DATA); end
    next_cycle();
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== 32'd31) begin n_fail++; $display("FAIL bp_pop2: got %b/%h want 1/0000001f", RSP_VALID, RSP_DATA); end
    next_cycle();
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", RSP_VALID); end
  endtask

  task automatic test_wrap();
    logic [32:0] q[$];
    logic [32:0] exp_e;
    logic [31:0] res;
    int issued;
    int cycles;
    idle_inputs();
    REQ_VALID = 2'b10; REQ_OP1 = ADD; REQ_A1 = 32'hFFFF_FFFF; REQ_B1 = 32'd1;
    #1;
    n_checks++; if (REQ_READY !== 2'b10) begin n_fail++; $display("FAIL wrap_rdy: got %b want 10", REQ_READY); end
    next_cycle();
    REQ_VALID = 2'b00;
    next_cycle();
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b1 || RSP_DATA !== 32'd0) begin n_fail++; $display("FAIL wrap_sum: got %b/%b/%h want 1/1/00000000", RSP_VALID, RSP_ID, RSP_DATA); end
    next_cycle();

    issued = 0;
    cycles = 0;
    while ((issued < 40 || q.size() != 0) && cycles < 2000) begin
      if (issued < 40) begin
        REQ_VALID = 2'($urandom_range(1, 3));
        REQ_OP0 = alu_op_e'(1'($urandom_range(0, 1)));
        REQ_OP1 = alu_op_e'(1'($urandom_range(0, 1)));
        REQ_A0 = $urandom(); REQ_B0 = $urandom();
        REQ_A1 = $urandom(); REQ_B1 = $urandom();
        RSP_READY = 1'($urandom_range(0, 1));
      end else begin
        REQ_VALID = 2'b00;
        RSP_READY = 1'b1;
      end
      #1;
      if (RSP_VALID && RSP_READY) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL random_extra: got %b/%h want no response", RSP_ID, RSP_DATA);
        end else begin
          exp_e = q.pop_front();
          if ({RSP_ID, RSP_DATA} !== exp_e) begin n_fail++; $display("FAIL random_order: got %b/%h want %b/%h", RSP_ID, RSP_DATA, exp_e[32], exp_e[31:0]); end
        end
      end
      n_checks++; if (REQ_READY === 2'b11) begin n_fail++; $display("FAIL random_onehot: got %b want at most one bit", REQ_READY); end
      if (REQ_READY[0] && REQ_VALID[0]) begin
        res = (REQ_OP0 == ADD) ? REQ_A0 + REQ_B0 : REQ_A0 - REQ_B0;
        q.push_back({1'b0, res});
        issued++;
      end else if (REQ_READY[1] && REQ_VALID[1]) begin
        res = (REQ_OP1 == ADD) ? REQ_A1 + REQ_B1 : REQ_A1 - REQ_B1;
        q.push_back({1'b1, res});
        issued++;
      end
      next_cycle();
      cycles++;
    end
    n_checks++; if (cycles >= 2000) begin n_fail++; $display("FAIL random_timeout: got %0d cycles want < 2000", cycles); end
    n_checks++; if (issued != 40 || q.size() != 0) begin n_fail++; $display("FAIL random_loss: got issued %0d pending %0d want 40/0", issued, q.size()); end
    #1;
    n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL random_drain: got %b want 0", RSP_VALID); end
  endtask

  task automatic test_reset_midflight();
    idle_inputs();
    REQ_VALID = 2'b01; REQ_OP0 = ADD; REQ_A0 = 32'd100; REQ_B0 = 32'd200;
    #1;
    n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL mid_accept: got %b want 01", REQ_READY); end
    next_cycle();
    REQ_VALID = 2'b00;
    RST = 1'b1;
    #1;
    n_checks++; if (RSP_VALID !== 1'b0 || REQ_READY !== 2'b00) begin n_fail++; $display("FAIL mid_in_reset: got %b/%b want 0/00", RSP_VALID, REQ_READY); end
    next_cycle();
    RST = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_discard%0d: got %b want 0", k, RSP_VALID); end
      next_cycle();
    end
    // Both valid: requester 0 wins only if the pointer was cleared.
    REQ_VALID = 2'b11; REQ_A0 = 32'd1; REQ_B0 = 32'd1; REQ_OP1 = SUB; REQ_A1 = 32'd9; REQ_B1 = 32'd9;
    #1;
    n_checks++; if (REQ_READY !== 2'b01) begin n_fail++; $display("FAIL mid_pointer: got %b want 01", REQ_READY); end
    next_cycle();
    REQ_VALID = 2'b00;
    next_cycle();
    n_checks++; if (RSP_VALID !== 1'b1 || RSP_ID !== 1'b0 || RSP_DATA !== 32'd2) begin n_fail++; $display("FAIL mid_after: got %b/%b/%h want 1/0/00000002", RSP_VALID, RSP_ID, RSP_DATA); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter RSP_DEPTH, default 2, response FIFO entries; SHALL be a power of two and at least 2.
REQ-002 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 REQ_VALID  input  2  per-requester request valid; bit i = requester i.
REQ-005 REQ_READY  output  2  per-requester accept; at most one bit high per cycle.
REQ-006 REQ_OP0, REQ_OP1  input  alu_op_e  operation per requester (ADD, SUB).
REQ-007 REQ_A0, REQ_B0, REQ_A1, REQ_B1  input  32  operands per requester.
REQ-008 ALU_CTR  output  control_info  control to the shared ALU; add/sub one-hot on issue, all-zero otherwise.
REQ-009 ALU_RS1, ALU_RS2  output  32  ALU operands; zero when not issuing.
REQ-010 ALU_RESULT  input  32  ALU registered result, valid exactly one cycle after issue.
REQ-011 RSP_VALID  output  1  response available at FIFO head.
REQ-012 RSP_READY  input  1  consumer accepts response.
REQ-013 RSP_ID  output  1  requester index of head response.
REQ-014 RSP_DATA  output  32  result of head response.

Function
REQ-015 A request SHALL be accepted in a cycle when REQ_VALID[i] and REQ_READY[i] are both high; acceptance SHALL drive ALU_CTR/ALU_RS1/ALU_RS2 combinationally from that requester in the same cycle.
REQ-016 REQ_READY[i] SHALL be high only when requester i wins arbitration and a slot is free (REQ-019); it SHALL depend combinationally on REQ_VALID, never the reverse.
REQ-017 Arbitration SHALL be round-robin: priority pointer starts at 0; after a grant to i the pointer SHALL move to 1-i; with one requester valid it wins regardless of pointer; pointer SHALL not move without a grant.
REQ-018 Issue-to-result: the arbiter SHALL capture ALU_RESULT with the issued ID into the FIFO at the end of the cycle following issue; RSP_VALID SHALL rise two cycles after acceptance when the FIFO was empty.
REQ-019 Slots: occupied = FIFO count + in-flight (0 or 1); issue allowed iff occupied minus (RSP_VALID and RSP_READY) < RSP_DEPTH.
REQ-020 With RSP_READY held high, one request per cycle SHALL be sustained (full throughput).
REQ-021 Simultaneous FIFO push and pop SHALL leave count unchanged; pop on empty or push on full SHALL never occur.
REQ-022 FIFO read/write pointers SHALL wrap modulo RSP_DEPTH; responses SHALL return in issue order.
REQ-023 RSP_ID/RSP_DATA SHALL hold stable while RSP_VALID is high and RSP_READY low.
REQ-024 ADD SHALL yield A+B, SUB A-B, modulo 2^32 (two's-complement wrap, no overflow flag).

Reset
REQ-025 While RST is high: REQ_READY=0, ALU_CTR=0, ALU_RS1=ALU_RS2=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, pointer=0, FIFO empty, in-flight cleared.
REQ-026 Reset asserted mid-operation SHALL discard in-flight and buffered results; the ALU_RESULT arriving the cycle after reset release SHALL NOT be captured.
REQ-027 First acceptance SHALL be possible in the first cycle RST is low.

Structure
REQ-028 alu_op_e (ADD=0, SUB=1) and control_info SHALL live in the shared def.sv package; RSP_DEPTH default SHALL be a package constant.
REQ-029 The response buffer SHALL be a sub-module rsp_fifo (parameterised depth, 33-bit entry: ID+data).
REQ-030 The ALU itself SHALL stay outside this block; the arbiter connects only through ALU_CTR/ALU_RS1/ALU_RS2/ALU_RESULT.

Verification
REQ-031 Single request: requester 0 ADD 5,7, RSP_READY=1 -> REQ_READY[0] same cycle, RSP_VALID two cycles later, RSP_ID=0, RSP_DATA=12.
REQ-032 Contention: both valid every cycle, requester1 SUB 3,5 -> grants alternate 0,1,0,1; requester1 responses RSP_DATA=0xFFFFFFFE.
REQ-033 Backpressure: RSP_READY=0, continuous requests -> exactly RSP_DEPTH accepted then REQ_READY=0; release RSP_READY -> responses in issue order, acceptance resumes same cycle as first pop.
REQ-034 Wrap: ADD 0xFFFFFFFF,1 -> RSP_DATA=0; 40 back-to-back ops with RSP_READY toggling randomly -> in-order, no loss, pointers wrap.
REQ-035 Reset mid-flight: accept op, assert RST next cycle for one cycle -> RSP_VALID never rises for that op; FIFO empty; pointer=0.
